vga_text_bitgen: RTL and testbench
==================================

Name: vga_text_bitgen

Overview:
- Pixel generator that sits directly downstream of the VGA timing controller and consumes its hSync, vSync, bright, hCount and vCount.
- Renders an 80x60 text screen of 8x8-pixel cells. Each cell's character code comes from an external character RAM; its pixel pattern comes from an external glyph ROM.
- Drives 8-bit RGB (3-3-2) to the DAC pins and re-times the sync signals to match the pipeline.
- Provides programmable foreground/background colours and a blinking block cursor through a small register write port.

Parameters:
- COLS, 80, characters per row (cell column 0..COLS-1)
- ROWS, 60, character rows (cell row 0..ROWS-1)
- HACTIVE, 640, visible pixels per line
- VACTIVE, 480, visible lines per frame
- BLINK_FRAMES, 30, vSync pulses between cursor blink toggles

Ports:
- clock  in  1  pixel clock (25 MHz)
- clear  in  1  asynchronous, active-high reset
- hSync_in  in  1  active-low horizontal sync from timing controller
- vSync_in  in  1  active-low vertical sync from timing controller
- bright_in  in  1  1 = active video
- hCount  in  10  pixel column from timing controller
- vCount  in  10  pixel line from timing controller
- char_addr  out  13  character RAM address, row*COLS+col, combinational
- char_data  in  8  character code, valid 1 clock after char_addr
- glyph_addr  out  11  {char_code, glyph_row[2:0]}, combinational from char_data and stage-1 registers
- glyph_data  in  8  glyph row bits, bit 7 = leftmost pixel, valid 1 clock after glyph_addr
- wr_en  in  1  register write strobe
- wr_addr  in  2  0 = fg colour, 1 = bg colour, 2 = cursor column, 3 = cursor row/enable
- wr_data  in  16  write data
- hSync  out  1  delayed hSync_in
- vSync  out  1  delayed vSync_in
- bright  out  1  delayed bright_in
- rgb  out  8  {R[2:0],G[2:0],B[1:0]}

Behaviour:
- Reset (async, clear=1):
  - rgb=0, hSync=1, vSync=1, bright=0.
  - fg=8'hFF, bg=8'h00, cursor col/row=0, cursor enabled=0.
  - blink_on=0, blink counter=0, all pipeline registers cleared.
  - Release is synchronous to the next clock edge.
- Cell computation (stage 0, combinational):
  - col = hCount[9:3], row = vCount[9:3].
  - char_addr = row*80 + col, implemented as (row<<6)+(row<<4)+col; 13-bit result, no overflow inside the active area.
  - If hCount>=HACTIVE or vCount>=VACTIVE, char_addr=0 and the pixel is marked invalid.
- Stage 1 (edge 1): register hCount[2:0], vCount[2:0], the valid flag, the cursor-match flag (col==cursor_col && row==cursor_row), hSync_in, vSync_in and bright_in.
  - glyph_addr = {char_data, stage-1 vCount[2:0]}.
- Stage 2 (edge 2): register stage-1 fields again; glyph_data is valid during this stage.
- Stage 3 (edge 3), pixel output:
  - pix = glyph_data[7 - stage-2 hCount[2:0]].
  - If cursor enabled && blink_on && cursor-match, then pix is inverted.
  - rgb = (bright_d && valid_d) ? (pix ? fg : bg) : 0.
- Latency: hSync, vSync, bright and rgb are exactly 3 clocks after the corresponding input sample. Syncs pass through untouched apart from the delay.
- Register writes (on a clock edge with wr_en=1):
  - addr0: fg = wr_data[7:0].
  - addr1: bg = wr_data[7:0].
  - addr2: cursor_col = wr_data[6:0].
  - addr3: cursor_row = wr_data[5:0], cursor enable = wr_data[15].
  - A write at edge N affects the rgb registered at edge N+1 onward. A stage-3 evaluation at edge N uses the old value.
  - Cursor values >= COLS/ROWS are stored as written and simply never match.
- Blink:
  - The block detects falling edges of vSync_in using a registered previous value; that register resets to 1.
  - Each falling edge increments the counter. When the counter reaches BLINK_FRAMES-1 and another edge arrives, the counter wraps to 0 and blink_on toggles.
  - Writing cursor enable=0 does not reset the counter.
- Reset mid-frame: all outputs return to reset values immediately. On release, the pipeline refills, and rgb is 0 for the first 3 clocks regardless of inputs.
- No backpressure: the block is free-running and accepts one pixel per clock.

Test Plan:
- Reset, then glyph_data=8'h80, char_data=8'h41, bright_in=1, hCount=0, vCount=0 → rgb=8'hFF exactly 3 clocks after sampling; hCount=1 → rgb=8'h00; char_addr=0, glyph_addr=11'h208.
- hCount=17, vCount=9 → char_addr=82; vCount=479, hCount=639 → char_addr=4799; hCount=700 with bright_in=1 → rgb=0.
- Toggle hSync_in/vSync_in with an arbitrary pattern → hSync/vSync reproduce it with a 3-clock delay; no glitches during reset release.
- Write fg=8'hE0, bg=8'h03 mid-line → the following pixels show 8'hE0 for set bits and 8'h03 for clear bits, starting at edge N+1.
- Cursor at col 5, row 2, enabled, BLINK_FRAMES=2 → blink_on toggles on every 2nd vSync falling edge; pixels hCount 40..47, vCount 16..23 show inverted colour only while blink_on=1.
- Assert clear during active video with blink_on=1 → rgb=0, syncs=1 immediately; after release, blink_on=0 and fg/bg are back to defaults.

Source files
------------

// File: rtl/vga_text_bitgen.sv
// ---------------------------------------------------------------------------
// vga_text_bitgen
//
// Text-mode pixel generator that sits directly behind the VGA timing
// controller. The screen is COLS x ROWS character cells of 8x8 pixels. For
// every pixel the block computes the character RAM address, turns the
// returned character code into a glyph ROM address, selects the glyph bit for
// the pixel and maps it to a foreground/background colour. A blinking block
// cursor inverts the pixels of one cell.
//
// Stream interface: there is no backpressure. One pixel is accepted on every
// clock edge and the matching rgb/hSync/vSync/bright leave exactly three
// register stages later. The external character RAM and glyph ROM must return
// data one clock after their address.
//
// Pipeline:
//   stage 0 (comb)  : cell col/row, char_addr, cursor match, valid flag
//   stage 1 (edge 1): pixel fields registered; char_data arrives,
//                     glyph_addr = {char_data, line within cell}
//   stage 2 (edge 2): fields registered again; glyph_data arrives
//   stage 3 (edge 3): colour lookup and output registers
//
// Ports:
//   clock       pixel clock
//   clear       asynchronous active-high reset
//   hSync_in    active-low horizontal sync from the timing controller
//   vSync_in    active-low vertical sync from the timing controller
//   bright_in   1 = active video
//   hCount      pixel column from the timing controller
//   vCount      pixel line from the timing controller
//   char_addr   character RAM address (row*COLS + col), combinational
//   char_data   character code, valid one clock after char_addr
//   glyph_addr  {char_code, glyph_row}, combinational from char_data
//   glyph_data  glyph row bits (bit 7 = leftmost), valid one clock later
//   wr_en       register write strobe
//   wr_addr     0 fg colour, 1 bg colour, 2 cursor column, 3 cursor row/enable
//   wr_data     register write data
//   hSync       hSync_in delayed to match rgb
//   vSync       vSync_in delayed to match rgb
//   bright      bright_in delayed to match rgb
//   rgb         pixel colour {R[2:0], G[2:0], B[1:0]}
// ---------------------------------------------------------------------------
module vga_text_bitgen #(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int HACTIVE      = 640,
  parameter int VACTIVE      = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        hSync_in,
  input  logic        vSync_in,
  input  logic        bright_in,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [12:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [10:0] glyph_addr,
  input  logic [7:0]  glyph_data,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic [7:0]  rgb
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // -------------------------------------------------------------------------
  // Programmable registers
  // -------------------------------------------------------------------------
  logic [7:0] fg;
  logic [7:0] bg;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic       cursor_en;

  // wr_data[14:8] carries no register field.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data[14:8];

  // Out-of-range cursor positions are stored as written; they simply never
  // match a visible cell.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      fg         <= 8'hFF;
      bg         <= 8'h00;
      cursor_col <= 7'd0;
      cursor_row <= 6'd0;
      cursor_en  <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        2'd0: fg <= wr_data[7:0];
        2'd1: bg <= wr_data[7:0];
        2'd2: cursor_col <= wr_data[6:0];
        2'd3: begin
          cursor_row <= wr_data[5:0];
          cursor_en  <= wr_data[15];
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Cursor blink: count falling edges of vSync_in, toggle every BLINK_FRAMES.
  // The counter keeps running while the cursor is disabled.
  // -------------------------------------------------------------------------
  logic          vs_prev;
  logic          vs_fall;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  assign vs_fall = vs_prev & ~vSync_in;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      vs_prev   <= 1'b1;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      vs_prev <= vSync_in;
      if (vs_fall) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 0: cell coordinates and character RAM address
  // -------------------------------------------------------------------------
  logic [6:0]  col;
  logic [6:0]  row;
  logic        in_area;
  logic [12:0] lin_addr;
  logic        cursor_hit;

  assign col     = hCount[9:3];
  assign row     = vCount[9:3];
  assign in_area = (hCount < 10'(HACTIVE)) && (vCount < 10'(VACTIVE));

  // row*80 without a multiplier: row*64 + row*16 + col.
  assign lin_addr = ({6'd0, row} << 6) + ({6'd0, row} << 4) + {6'd0, col};
  assign char_addr = in_area ? lin_addr : 13'd0;

  assign cursor_hit = (col == cursor_col) && (row == {1'b0, cursor_row});

  // -------------------------------------------------------------------------
  // Stage 1
  // -------------------------------------------------------------------------
  logic [2:0] s1_hpix;
  logic [2:0] s1_vrow;
  logic       s1_valid;
  logic       s1_cur;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_br;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s1_hpix  <= 3'd0;
      s1_vrow  <= 3'd0;
      s1_valid <= 1'b0;
      s1_cur   <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_br    <= 1'b0;
    end else begin
      s1_hpix  <= hCount[2:0];
      s1_vrow  <= vCount[2:0];
      s1_valid <= in_area;
      s1_cur   <= cursor_hit;
      s1_hs    <= hSync_in;
      s1_vs    <= vSync_in;
      s1_br    <= bright_in;
    end
  end

  // char_data belongs to the pixel now held in stage 1.
  assign glyph_addr = {char_data, s1_vrow};

  // -------------------------------------------------------------------------
  // Stage 2 (the line within the cell is no longer needed here)
  // -------------------------------------------------------------------------
  logic [2:0] s2_hpix;
  logic       s2_valid;
  logic       s2_cur;
  logic       s2_hs;
  logic       s2_vs;
  logic       s2_br;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s2_hpix  <= 3'd0;
      s2_valid <= 1'b0;
      s2_cur   <= 1'b0;
      s2_hs    <= 1'b1;
      s2_vs    <= 1'b1;
      s2_br    <= 1'b0;
    end else begin
      s2_hpix  <= s1_hpix;
      s2_valid <= s1_valid;
      s2_cur   <= s1_cur;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      s2_br    <= s1_br;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: colour lookup. fg/bg/cursor_en/blink_on are read as registered,
  // so a write at edge N first shows in the rgb registered at edge N+1.
  // -------------------------------------------------------------------------
  logic       pix_raw;
  logic       pix;
  logic [7:0] rgb_next;

  always_comb begin
    pix_raw  = glyph_data[3'd7 - s2_hpix];
    pix      = pix_raw ^ (cursor_en & blink_on & s2_cur);
    rgb_next = 8'h00;
    if (s2_br && s2_valid) begin
      rgb_next = pix ? fg : bg;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rgb    <= 8'h00;
      hSync  <= 1'b1;
      vSync  <= 1'b1;
      bright <= 1'b0;
    end else begin
      rgb    <= rgb_next;
      hSync  <= s2_hs;
      vSync  <= s2_vs;
      bright <= s2_br;
    end
  end

endmodule

// File: tb/tb_vga_text_bitgen.sv
// ---------------------------------------------------------------------------
// Testbench for vga_text_bitgen.
//   - directed table of single-pixel vectors held steady for three clocks
//   - streamed sequences with a reference model and an expected queue
//     (sync pattern, mid-line colour writes, blinking cursor, reset refill)
// ---------------------------------------------------------------------------
module tb_vga_text_bitgen;

  localparam int BF = 2;

  // ---------------- clock / reset ----------------
  logic clock;
  logic clear;
  initial clock = 1'b0;
  always #20 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic        hSync_in, vSync_in, bright_in;
  logic [9:0]  hCount, vCount;
  logic [12:0] char_addr;
  logic [7:0]  char_data;
  logic [10:0] glyph_addr;
  logic [7:0]  glyph_data;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        hSync, vSync, bright;
  logic [7:0]  rgb;

  vga_text_bitgen #(.BLINK_FRAMES(BF)) dut (
    .clock(clock), .clear(clear),
    .hSync_in(hSync_in), .vSync_in(vSync_in), .bright_in(bright_in),
    .hCount(hCount), .vCount(vCount),
    .char_addr(char_addr), .char_data(char_data),
    .glyph_addr(glyph_addr), .glyph_data(glyph_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hSync(hSync), .vSync(vSync), .bright(bright), .rgb(rgb)
  );

  // ---------------- external memory model ----------------
  logic       use_mem;
  logic [7:0] tb_char, tb_glyph, mem_char, mem_glyph;

  function automatic logic [7:0] ram_f(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  function automatic logic [7:0] rom_f(input logic [7:0] code, input logic [2:0] r);
    return code ^ {r, 2'b01, r};
  endfunction

  always @(posedge clock) begin
    mem_char  <= ram_f(char_addr);
    mem_glyph <= rom_f(glyph_addr[10:3], glyph_addr[2:0]);
  end

  assign char_data  = use_mem ? mem_char  : tb_char;
  assign glyph_data = use_mem ? mem_glyph : tb_glyph;

  // ---------------- scoreboard ----------------
  int checks;
  int failures;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // {hs, vs, br, valid, pix_raw, cursor_match}
  logic [5:0] exp_q[$];
  localparam logic [5:0] RESET_ENTRY = 6'b110000;

  // reference model of programmable state
  logic [7:0] m_fg, m_bg;
  logic [6:0] m_ccol;
  logic [5:0] m_crow;
  logic       m_en, m_blink, m_prev_vs;
  int         m_cnt;

  task automatic model_reset();
    m_fg = 8'hFF; m_bg = 8'h00; m_ccol = 7'd0; m_crow = 6'd0;
    m_en = 1'b0; m_blink = 1'b0; m_prev_vs = 1'b1; m_cnt = 0;
    exp_q.delete();
    exp_q.push_back(RESET_ENTRY);
    exp_q.push_back(RESET_ENTRY);
  endtask

  typedef struct {
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        br;
    logic        hs;
    logic        vs;
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
  } step_t;

  step_t steps[$];

  task automatic add_step(input logic [9:0] hc, input logic [9:0] vc, input logic br,
                          input logic hs, input logic vs, input logic we,
                          input logic [1:0] wa, input logic [15:0] wd);
    step_t s;
    s.hc = hc; s.vc = vc; s.br = br; s.hs = hs; s.vs = vs;
    s.we = we; s.wa = wa; s.wd = wd;
    steps.push_back(s);
  endtask

  task automatic model_apply(input step_t s);
    if (s.we) begin
      case (s.wa)
        2'd0: m_fg = s.wd[7:0];
        2'd1: m_bg = s.wd[7:0];
        2'd2: m_ccol = s.wd[6:0];
        default: begin m_crow = s.wd[5:0]; m_en = s.wd[15]; end
      endcase
    end
    if (m_prev_vs && !s.vs) begin
      if (m_cnt == BF - 1) begin
        m_cnt = 0;
        m_blink = ~m_blink;
      end else begin
        m_cnt++;
      end
    end
    m_prev_vs = s.vs;
  endtask

  // ---------------- driver ----------------
  task automatic drive_pixel(input logic [9:0] hc, input logic [9:0] vc, input logic br,
                             input logic hs, input logic vs);
    hCount = hc; vCount = vc; bright_in = br; hSync_in = hs; vSync_in = vs;
  endtask

  task automatic run_steps();
    step_t      s;
    logic       valid, pix, match;
    int         a;
    logic [12:0] exp_addr;
    logic [7:0] code, g, exp_rgb;
    logic [5:0] e;
    for (int k = 0; k < steps.size(); k++) begin
      s = steps[k];
      drive_pixel(s.hc, s.vc, s.br, s.hs, s.vs);
      wr_en = s.we; wr_addr = s.wa; wr_data = s.wd;
      valid = (s.hc < 10'd640) && (s.vc < 10'd480);
      a = valid ? (int'(s.vc) / 8) * 80 + int'(s.hc) / 8 : 0;
      exp_addr = a[12:0];
      code = ram_f(exp_addr);
      g = rom_f(code, s.vc[2:0]);
      pix = g[3'd7 - s.hc[2:0]];
      match = (int'(s.hc) / 8 == int'(m_ccol)) && (int'(s.vc) / 8 == int'(m_crow));
      exp_q.push_back({s.hs, s.vs, s.br, valid, pix, match});
      @(posedge clock);
      #1;
      check_val("stream_char_addr", char_addr, exp_addr);
      e = exp_q.pop_front();
      exp_rgb = (e[3] && e[2]) ? (((e[1] ^ (m_en & m_blink & e[0])) != 1'b0) ? m_fg : m_bg) : 8'h00;
      check_val("stream_out", {hSync, vSync, bright, rgb}, {e[5], e[4], e[3], exp_rgb});
      model_apply(s);
    end
    wr_en = 1'b0;
    steps.delete();
  endtask

  task automatic do_reset();
    clear = 1'b1;
    wr_en = 1'b0;
    drive_pixel(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    model_reset();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        br;
    logic        hs;
    logic        vs;
    logic [7:0]  cd;
    logic [7:0]  gd;
    logic [12:0] exp_ca;
    logic [10:0] exp_ga;
    logic [7:0]  exp_rgb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] hpat, vpat;
    int guard;

    checks = 0; failures = 0;
    use_mem = 1'b0; tb_char = 8'h00; tb_glyph = 8'h00;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0000;
    clear = 1'b1;

    //            hc    vc   br  hs  vs  cd     gd     char_addr   glyph_addr rgb
    vecs[0] = '{10'd0,   10'd0,   1, 1, 1, 8'h41, 8'h80, 13'd0,    11'h208, 8'hFF};
    vecs[1] = '{10'd1,   10'd0,   1, 1, 1, 8'h41, 8'h80, 13'd0,    11'h208, 8'h00};
    vecs[2] = '{10'd17,  10'd9,   1, 1, 1, 8'h41, 8'h40, 13'd82,   11'h209, 8'hFF};
    vecs[3] = '{10'd639, 10'd479, 1, 1, 1, 8'h41, 8'h01, 13'd4799, 11'h20F, 8'hFF};
    vecs[4] = '{10'd700, 10'd0,   1, 1, 1, 8'h41, 8'hFF, 13'd0,    11'h208, 8'h00};
    vecs[5] = '{10'd0,   10'd480, 1, 1, 1, 8'h41, 8'hFF, 13'd0,    11'h208, 8'h00};
    vecs[6] = '{10'd0,   10'd0,   0, 0, 1, 8'h41, 8'hFF, 13'd0,    11'h208, 8'h00};
    vecs[7] = '{10'd320, 10'd240, 1, 1, 0, 8'h7E, 8'h00, 13'd2440, 11'h3F0, 8'h00};
    vecs[8] = '{10'd645, 10'd10,  1, 0, 0, 8'h12, 8'hFF, 13'd0,    11'h092, 8'h00};
    vecs[9] = '{10'd639, 10'd0,   1, 1, 1, 8'hFF, 8'h01, 13'd79,   11'h7F8, 8'hFF};

    // Reset state with non-idle inputs applied.
    drive_pixel(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    tb_char = 8'h41; tb_glyph = 8'hFF;
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_out", {hSync, vSync, bright, rgb}, {1'b1, 1'b1, 1'b0, 8'h00});

    do_reset();

    // Table vectors: inputs held steady through the three pipeline stages.
    for (int i = 0; i < 10; i++) begin
      drive_pixel(vecs[i].hc, vecs[i].vc, vecs[i].br, vecs[i].hs, vecs[i].vs);
      tb_char = vecs[i].cd; tb_glyph = vecs[i].gd;
      repeat (3) @(posedge clock);
      #1;
      check_val($sformatf("vec%0d_char_addr", i), char_addr, vecs[i].exp_ca);
      check_val($sformatf("vec%0d_glyph_addr", i), glyph_addr, vecs[i].exp_ga);
      check_val($sformatf("vec%0d_out", i), {hSync, vSync, bright, rgb},
                {vecs[i].hs, vecs[i].vs, vecs[i].br, vecs[i].exp_rgb});
    end

    // Streamed sequences through the memory model.
    do_reset();
    use_mem = 1'b1;

    // A: sync pattern, bright gap, active/invalid boundary, fg/bg writes mid-line.
    hpat = 16'b1011_0010_1110_0101;
    vpat = 16'b1101_1110_0111_1011;
    for (int k = 0; k < 40; k++) begin
      add_step(10'(620 + k), 10'd37, !(k == 5 || k == 6), hpat[k % 16], vpat[k % 16],
               (k == 15 || k == 16), (k == 15) ? 2'd0 : 2'd1,
               (k == 15) ? 16'h00E0 : 16'h0003);
    end
    run_steps();

    // B: cursor at col 5 row 2, enabled, across several vSync pulses.
    add_step(10'd0, 10'd0, 1, 1, 1, 1, 2'd2, 16'h0005);
    add_step(10'd0, 10'd0, 1, 1, 1, 1, 2'd3, 16'h8002);
    for (int f = 0; f < 6; f++) begin
      for (int h = 36; h < 50; h++) add_step(10'(h), 10'(16 + f), 1, 1, 1, 0, 2'd0, 16'h0);
      add_step(10'd44, 10'd24, 1, 1, 1, 0, 2'd0, 16'h0);
      add_step(10'd44, 10'd15, 1, 1, 1, 0, 2'd0, 16'h0);
      add_step(10'd0, 10'd0, 0, 1, 0, 0, 2'd0, 16'h0);
      add_step(10'd0, 10'd0, 0, 1, 0, 0, 2'd0, 16'h0);
      add_step(10'd0, 10'd0, 0, 1, 1, 0, 2'd0, 16'h0);
    end
    run_steps();

    // Make sure the cursor is in its visible phase before the mid-frame reset.
    guard = 0;
    while (!m_blink && guard < 4) begin
      add_step(10'd0, 10'd0, 0, 1, 0, 0, 2'd0, 16'h0);
      add_step(10'd0, 10'd0, 0, 1, 1, 0, 2'd0, 16'h0);
      for (int h = 40; h < 48; h++) add_step(10'(h), 10'd17, 1, 1, 1, 0, 2'd0, 16'h0);
      run_steps();
      guard++;
    end
    check_val("blink_phase_before_reset", {31'd0, m_blink}, 32'd1);

    // C: asynchronous reset during active video inside the cursor cell.
    drive_pixel(10'd40, 10'd16, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    check_val("pre_reset_hsync", {31'd0, hSync}, 32'd0);
    #5;
    clear = 1'b1;
    #1;
    check_val("midframe_reset_out", {hSync, vSync, bright, rgb}, {1'b1, 1'b1, 1'b0, 8'h00});
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    model_reset();
    check_val("release_out", {hSync, vSync, bright, rgb}, {1'b1, 1'b1, 1'b0, 8'h00});
    for (int h = 0; h < 16; h++) add_step(10'(h), 10'd8, 1, 1, 1, 0, 2'd0, 16'h0);
    for (int h = 40; h < 48; h++) add_step(10'(h), 10'd16, 1, 1, 1, 0, 2'd0, 16'h0);
    run_steps();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "time limit reached");
  end

endmodule
